// File: rtl/frequency_meter.sv
// frequency_meter
//   Counts rising edges of an asynchronous input over a fixed window of
//   GATE_CYCLES clock_in cycles, publishing the count with a one-cycle valid
//   pulse. Windows run back-to-back while enable is held high.
//
// Ports
//   clock_in   : block clock
//   rst_n      : asynchronous active-low reset
//   enable     : high runs measurement windows, low aborts / idles
//   signal_in  : asynchronous signal under measurement
//   freq_count : rising edges counted in the last completed window
//   freq_valid : one-cycle pulse when freq_count updates
//   overflow   : last completed window saturated the edge counter
//   busy       : a window is in progress
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no window running, waiting for enable
// MEASURE | window in progress, gate counter advancing
module frequency_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int COUNT_WIDTH = 28
) (
    input  logic                   clock_in,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   signal_in,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   freq_valid,
    output logic                   overflow,
    output logic                   busy
);
    localparam int GATE_WIDTH = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t                 state;
    logic                   sync_s1;
    logic                   sync_s2;
    logic                   sync_s3;
    logic [1:0]             prime_cnt;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   sat_flag;

    logic                   edge_pulse;
    logic                   edge_at_max;
    logic [COUNT_WIDTH-1:0] edge_next;
    logic                   sat_next;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    // The prime counter masks the pulse that would otherwise appear when
    // signal_in is already high as the flops come out of reset.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1   <= 1'b0;
            sync_s2   <= 1'b0;
            sync_s3   <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            sync_s1 <= signal_in;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
            if (prime_cnt != 2'd3) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign edge_pulse  = sync_s2 & ~sync_s3 & (prime_cnt == 2'd3);
    assign edge_at_max = edge_pulse && (edge_cnt == COUNT_MAX);
    assign edge_next   = (edge_pulse && !edge_at_max) ? edge_cnt + COUNT_WIDTH'(1) : edge_cnt;
    assign sat_next    = sat_flag | edge_at_max;

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_flag   <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= MEASURE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        // Last window cycle: an edge arriving now is included,
                        // and the next window starts without a dead cycle.
                        freq_count <= edge_next;
                        overflow   <= sat_next;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat_flag   <= 1'b0;
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_WIDTH'(1);
                        edge_cnt <= edge_next;
                        sat_flag <= sat_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frequency_meter.sv
module tb_frequency_meter;
    localparam int G    = 100;
    localparam int HMAX = 20000;

    logic       clock_in  = 1'b0;
    logic       rst_n     = 1'b1;
    logic       enable    = 1'b0;
    logic       signal_in = 1'b0;

    logic [7:0] freq_count8;
    logic       freq_valid8, overflow8, busy8;
    logic [3:0] freq_count4;
    logic       freq_valid4, overflow4, busy4;

    frequency_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(8)) dut8 (
        .clock_in(clock_in), .rst_n(rst_n), .enable(enable), .signal_in(signal_in),
        .freq_count(freq_count8), .freq_valid(freq_valid8), .overflow(overflow8), .busy(busy8)
    );

    frequency_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(4)) dut4 (
        .clock_in(clock_in), .rst_n(rst_n), .enable(enable), .signal_in(signal_in),
        .freq_count(freq_count4), .freq_valid(freq_valid4), .overflow(overflow4), .busy(busy4)
    );

    always #5 clock_in = ~clock_in;

    int tests = 0;
    int fails = 0;

    // Cycle n is the interval after the n-th rising clock edge.
    int cyc = 0;
    int rel = 0;
    bit sig_hist [HMAX];
    bit en_hist  [HMAX];

    // Reference model: windows described by their start cycle.
    bit         m_active = 1'b0;
    bit         m_valid  = 1'b0;
    int         m_ws     = 0;
    logic [7:0] m_cnt8   = '0;
    logic [3:0] m_cnt4   = '0;
    bit         m_ovf8   = 1'b0;
    bit         m_ovf4   = 1'b0;

    // Stimulus generator: 0 constant, 1 square wave, 2 random, 3 manual.
    int mode      = 0;
    bit sig_const = 1'b0;
    int sq_high   = 1;
    int sq_low    = 1;
    int sq_pos    = 0;

    typedef struct {
        int high;
        int low;
        int exp8;
        int exp4;
        int ovf4;
    } vec_t;
    vec_t vecs [6];

    // A rising transition of the input between cycles n-1 and n is seen as an
    // edge in cycle n+2; it counts if that cycle lies in the window and the
    // synchronizer had three edges of history since reset release.
    function automatic int window_edges(input int ws);
        int e = 0;
        for (int n = ws - 2; n <= ws + G - 3; n++) begin
            if (n >= rel + 1 && n >= 1 && sig_hist[n] && !sig_hist[n-1]) e++;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_cnt8   = '0;
        m_cnt4   = '0;
        m_ovf8   = 1'b0;
        m_ovf4   = 1'b0;
    endtask

    task automatic model_step();
        int p;
        int e;
        p = cyc - 1;
        m_valid = 1'b0;
        if (m_active) begin
            if (p == m_ws + G - 1) begin
                e = window_edges(m_ws);
                m_cnt8  = 8'((e > 255) ? 255 : e);
                m_ovf8  = (e > 255);
                m_cnt4  = 4'((e > 15) ? 15 : e);
                m_ovf4  = (e > 15);
                m_valid = 1'b1;
                if (en_hist[p]) m_ws = cyc;
                else m_active = 1'b0;
            end else if (!en_hist[p]) begin
                m_active = 1'b0;
            end
        end else if (en_hist[p]) begin
            m_active = 1'b1;
            m_ws     = cyc;
        end
    endtask

    task automatic check_cycle();
        tests++;
        if (busy8 !== m_active || freq_valid8 !== m_valid || busy4 !== m_active || freq_valid4 !== m_valid) begin
            fails++;
            $display("FAIL cycle %0d busy/valid: got busy=%b/%b valid=%b/%b, want busy=%b valid=%b",
                     cyc, busy8, busy4, freq_valid8, freq_valid4, m_active, m_valid);
        end
        tests++;
        if (freq_count8 !== m_cnt8 || overflow8 !== m_ovf8 || freq_count4 !== m_cnt4 || overflow4 !== m_ovf4) begin
            fails++;
            $display("FAIL cycle %0d count/ovf: got w8=%0d/%b w4=%0d/%b, want w8=%0d/%b w4=%0d/%b",
                     cyc, freq_count8, overflow8, freq_count4, overflow4, m_cnt8, m_ovf8, m_cnt4, m_ovf4);
        end
    endtask

    task automatic gen_signal();
        case (mode)
            0: signal_in = sig_const;
            1: begin
                sq_pos++;
                signal_in = ((sq_pos % (sq_high + sq_low)) < sq_high);
            end
            2: signal_in = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic tick();
        if (cyc >= HMAX - 1) begin
            $display("FAIL history: cycle budget %0d exhausted", HMAX);
            $fatal(1, "cycle budget exhausted");
        end
        sig_hist[cyc] = signal_in;
        en_hist[cyc]  = enable;
        @(posedge clock_in);
        #1;
        cyc++;
        if (rst_n) model_step();
        check_cycle();
        gen_signal();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int bound, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (n < bound && !got) begin
            tick();
            n++;
            got = freq_valid8;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL wait_valid: no freq_valid within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if (freq_count8 !== '0 || freq_valid8 !== 1'b0 || overflow8 !== 1'b0 || busy8 !== 1'b0 ||
            freq_count4 !== '0 || freq_valid4 !== 1'b0 || overflow4 !== 1'b0 || busy4 !== 1'b0) begin
            fails++;
            $display("FAIL %s: got w8 cnt=%0d v=%b o=%b b=%b w4 cnt=%0d v=%b o=%b b=%b, want all 0",
                     name, freq_count8, freq_valid8, overflow8, busy8,
                     freq_count4, freq_valid4, overflow4, busy4);
        end
    endtask

    initial begin
        int n;
        int vseen;

        vecs[0] = '{high: 1,  low: 1,  exp8: 50, exp4: 15, ovf4: 1};
        vecs[1] = '{high: 5,  low: 5,  exp8: 10, exp4: 10, ovf4: 0};
        vecs[2] = '{high: 2,  low: 2,  exp8: 25, exp4: 15, ovf4: 1};
        vecs[3] = '{high: 2,  low: 3,  exp8: 20, exp4: 15, ovf4: 1};
        vecs[4] = '{high: 10, low: 10, exp8: 5,  exp4: 5,  ovf4: 0};
        vecs[5] = '{high: 50, low: 50, exp8: 1,  exp4: 1,  ovf4: 0};

        // Power-on reset
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("reset_state");
        ticks(3);
        #2 rst_n = 1'b1;
        rel = cyc;
        ticks(5);

        // Square waves with periods dividing the window: every window is exact
        enable = 1'b1;
        foreach (vecs[i]) begin
            mode    = 1;
            sq_high = vecs[i].high;
            sq_low  = vecs[i].low;
            sq_pos  = 0;
            wait_valid(2 * G, n);
            wait_valid(2 * G, n);
            check_eq($sformatf("vec%0d_spacing", i), n, G);
            check_eq($sformatf("vec%0d_count8", i), int'(freq_count8), vecs[i].exp8);
            check_eq($sformatf("vec%0d_ovf8", i), int'(overflow8), 0);
            check_eq($sformatf("vec%0d_count4", i), int'(freq_count4), vecs[i].exp4);
            check_eq($sformatf("vec%0d_ovf4", i), int'(overflow4), vecs[i].ovf4);
            check_eq($sformatf("vec%0d_busy", i), int'(busy8), 1);
        end

        // Abort at window cycle 40, then a fresh full window
        sq_high = 5;
        sq_low  = 5;
        sq_pos  = 0;
        wait_valid(2 * G, n);
        wait_valid(2 * G, n);
        ticks(40);
        enable = 1'b0;
        tick();
        check_eq("abort_busy", int'(busy8), 0);
        check_eq("abort_count_held", int'(freq_count8), 10);
        vseen = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (freq_valid8) vseen++;
        end
        check_eq("abort_no_valid", vseen, 0);
        enable = 1'b1;
        wait_valid(2 * G, n);
        check_eq("reenable_latency", n, G + 1);
        check_eq("reenable_count", int'(freq_count8), 10);

        // Asynchronous reset at window cycle 60
        ticks(60);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("async_reset");
        ticks(3);
        #2 rst_n = 1'b1;
        rel = cyc;
        wait_valid(2 * G, n);
        check_eq("post_reset_latency", n, G + 1);

        // Input already high when reset releases: no false edge
        mode      = 0;
        sig_const = 1'b1;
        ticks(20);
        #2 rst_n = 1'b0;
        model_reset();
        ticks(3);
        #2 rst_n = 1'b1;
        rel = cyc;
        wait_valid(2 * G, n);
        check_eq("high_at_reset_count8", int'(freq_count8), 0);
        check_eq("high_at_reset_count4", int'(freq_count4), 0);

        // Single edge landing on the last window cycle
        mode      = 3;
        signal_in = 1'b0;
        enable    = 1'b0;
        ticks(5);
        enable = 1'b1;
        ticks(98);
        signal_in = 1'b1;
        wait_valid(2 * G, n);
        check_eq("edge_last_cycle", int'(freq_count8), 1);
        wait_valid(2 * G, n);
        check_eq("edge_last_cycle_next", int'(freq_count8), 0);

        // Single edge landing on cycle 0 of the following window
        signal_in = 1'b0;
        enable    = 1'b0;
        ticks(5);
        enable = 1'b1;
        ticks(99);
        signal_in = 1'b1;
        wait_valid(2 * G, n);
        check_eq("edge_first_cycle_prev", int'(freq_count8), 0);
        wait_valid(2 * G, n);
        check_eq("edge_first_cycle_next", int'(freq_count8), 1);

        // Random input with occasional enable drops, checked cycle by cycle
        mode = 2;
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(0, 299) != 0);
            tick();
        end
        enable = 1'b0;
        ticks(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frequency_meter.md
# frequency_meter

Measures the frequency of an external or divided-down clock-like signal by counting its rising edges over a fixed gate window of `clock_in` cycles. It is the receiving end of the frequency-divider outputs: it checks divider ratios on the board and monitors external clocks. It publishes a registered count with a one-cycle valid pulse, and runs measurement windows back-to-back while enabled.

## Interface
Parameters:
- `GATE_CYCLES`, default 100000000: window length in `clock_in` cycles (1 s at 100 MHz); must be ≥ 2.
- `COUNT_WIDTH`, default 28: width of the edge counter and result.

Ports:
- `clock_in`, input, 1 bit: the block's single clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `enable`, input, 1 bit: synchronous to `clock_in`. High runs measurement windows; low aborts or idles.
- `signal_in`, input, 1 bit: asynchronous signal under measurement.
- `freq_count`, output, `COUNT_WIDTH` bits: rising edges counted in the last completed window.
- `freq_valid`, output, 1 bit: one-cycle pulse when `freq_count` updates.
- `overflow`, output, 1 bit: the last completed window saturated the edge counter.
- `busy`, output, 1 bit: high while a window is in progress (state MEASURE).

## Operation
- **Synchronizer:** `signal_in` passes through 2 flops (s1, s2) plus a history flop s3.
  - Edge pulse = s2 & ~s3.
  - Input-to-pulse latency is 3 `clock_in` cycles.
- **Prime counter (2 bits):** edge pulses are ignored until 3 clock edges have occurred after reset release. This prevents a false edge when `signal_in` is already high at reset.
- **States:**
  - IDLE:
    - `enable`=1 → MEASURE. Gate counter and edge counter are cleared.
    - `enable`=0 → stay in IDLE.
  - MEASURE, gate counter at g = 0 … GATE_CYCLES-1:
    - Each cycle, g increments.
    - Each cycle with a valid edge pulse, the edge counter increments.
    - At g = GATE_CYCLES-1 (last window cycle):
      - an edge in that same cycle is included;
      - `freq_count` is loaded with the final count;
      - `overflow` is loaded with the saturation flag;
      - `freq_valid` pulses.
      - If `enable`=1, the state stays MEASURE: g←0, edge counter←0, and the next window starts with no dead cycle.
      - If `enable`=0, the state → IDLE.
    - `enable`=0 before the last cycle: abort → IDLE. No `freq_valid`; `freq_count` and `overflow` keep their previous values.
- **Saturation:** the edge counter stops at 2^COUNT_WIDTH-1 and sets an internal sticky flag, cleared at each window start. The flag is copied to `overflow` with the result.
- **Gate counter width:** $clog2(GATE_CYCLES). It never wraps; reaching GATE_CYCLES-1 ends the window.
- **Input range:** inputs faster than `clock_in`/2 are undefined and not detected. An input toggling every cycle yields GATE_CYCLES/2 edges.

## Timing
- **Reset** (`rst_n`=0, any time, including mid-window):
  - state=IDLE;
  - `freq_count`=0, `freq_valid`=0, `overflow`=0, `busy`=0;
  - all counters and synchronizer flops = 0.
  - An in-progress window is discarded.
- **Window start:** window cycle 0 is the cycle after `enable` is first sampled high in IDLE. `busy` rises in that same cycle.
- **Window length:** exactly GATE_CYCLES cycles. An edge pulse is counted if it occurs in window cycles 0 … GATE_CYCLES-1.
- **Result timing:** the result is registered at the clock edge closing cycle GATE_CYCLES-1. `freq_count`, `overflow` and `freq_valid`=1 are visible in the following cycle.
  - In continuous mode, that following cycle is window cycle 0 of the next window.
- **`freq_valid` pulse:** high for exactly 1 cycle; back-to-back windows give one pulse every GATE_CYCLES cycles.
- **`busy` on completion:** falls in the cycle `freq_valid` is high if `enable`=0 at window end.
- **Abort:** `enable` sampled 0 during MEASURE (before the last cycle) → IDLE next cycle; `busy`=0.
- **Coincident events:** an edge coinciding with the last window cycle counts in the closing window. An edge in the first cycle of the next window counts in the new window.

## Test plan
Benches use GATE_CYCLES=100 and COUNT_WIDTH=8 unless stated.
1. Reset, `enable`=1 held, `signal_in` square wave with period 10 cycles (phase arbitrary) → after the first window, `freq_count`=10, `overflow`=0, `freq_valid` pulses every 100 cycles, `busy` stays 1.
2. `signal_in` toggling every cycle (period 2) → `freq_count`=50. `signal_in` held high from before reset release → `freq_count`=0 (no false edge).
3. COUNT_WIDTH=4 with period-2 input → `freq_count`=15, `overflow`=1. The next window with period-10 input → `freq_count`=10, `overflow`=0.
4. `enable` dropped at window cycle 40 → no `freq_valid`, `freq_count` holds the prior value, `busy`=0 the next cycle. Re-enabling starts a fresh full 100-cycle window.
5. `rst_n` asserted mid-window at cycle 60 → all outputs 0 immediately (asynchronous), no `freq_valid`. After release with `enable`=1, the first result appears 100 cycles after window start.
6. A single input edge placed so its pulse lands on window cycle 99 → counted in that window (`freq_count`=1). Placed so it lands on cycle 0 of the next window → counted there.
